// File: rtl/tc_digital_io_bank.sv
// Generic multi-channel bidirectional IO bank: per-channel pad config, direction turnaround FSM,
// input synchroniser and debounce filter. Define TC_IO_BANK_PULL_EN to model weak pull drivers.
module tc_digital_io_bank #(
    parameter int unsigned NumIo            = 8,
    parameter int unsigned SyncStages       = 2,
    parameter int unsigned DebounceW        = 4,
    parameter int unsigned TurnaroundCycles = 2,
    localparam int unsigned IdxW            = (NumIo > 1) ? $clog2(NumIo) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumIo-1:0]     data_i,
    output logic [NumIo-1:0]     data_o,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  logic                 cfg_oe_ni_i,
    input  logic [3:0]           cfg_strength_i,
    input  logic                 cfg_pullup_i,
    input  logic                 cfg_pulldown_i,
    input  logic [DebounceW-1:0] cfg_debounce_i,
    output logic [NumIo-1:0]     oe_no,
    output logic [NumIo-1:0]     busy_o,
    output logic [4*NumIo-1:0]   strength_o,
    inout  wire  [NumIo-1:0]     io
);

    localparam int unsigned TurnW = (TurnaroundCycles > 1) ? $clog2(TurnaroundCycles) : 1;
    localparam logic [TurnW-1:0] TurnInit =
        TurnW'((TurnaroundCycles > 0) ? TurnaroundCycles - 1 : 0);

    typedef enum logic [1:0] {StInput, StTurn, StDrive} state_e;

    state_e               r_state      [NumIo];
    state_e               w_state_d    [NumIo];
    logic [TurnW-1:0]     r_turn_cnt   [NumIo];
    logic [TurnW-1:0]     w_turn_cnt_d [NumIo];
    logic [3:0]           r_strength   [NumIo];
    logic [DebounceW-1:0] r_thresh     [NumIo];
    logic [DebounceW-1:0] r_cnt        [NumIo];
    logic [SyncStages-1:0] r_sync      [NumIo];
    logic [NumIo-1:0]     r_tgt_drive;
    logic [NumIo-1:0]     w_tgt_drive_d;
    logic [NumIo-1:0]     r_pullup;
    logic [NumIo-1:0]     r_pulldown;
    logic [NumIo-1:0]     r_data;
    logic [NumIo-1:0]     w_sel;
    logic                 w_busy_sel;
    logic                 w_idx_ok;
    logic                 w_accept;

    always_comb begin
        w_busy_sel = 1'b0;
        for (int unsigned k = 0; k < NumIo; k++) begin
            if (cfg_idx_i == IdxW'(k)) w_busy_sel = busy_o[k];
        end
    end

    assign w_idx_ok    = (32'(cfg_idx_i) < NumIo);
    assign cfg_ready_o = w_idx_ok && !w_busy_sel;
    assign w_accept    = cfg_valid_i && cfg_ready_o;

    always_comb begin
        w_sel = '0;
        for (int unsigned k = 0; k < NumIo; k++) begin
            w_sel[k] = w_accept && (cfg_idx_i == IdxW'(k));
        end
    end

    // Only a write that flips direction leaves INPUT/DRIVE; TURN counts down to its target.
    always_comb begin
        for (int unsigned k = 0; k < NumIo; k++) begin
            w_state_d[k]     = r_state[k];
            w_turn_cnt_d[k]  = r_turn_cnt[k];
            w_tgt_drive_d[k] = r_tgt_drive[k];
            unique case (r_state[k])
                StInput: begin
                    if (w_sel[k] && !cfg_oe_ni_i) begin
                        w_tgt_drive_d[k] = 1'b1;
                        w_turn_cnt_d[k]  = TurnInit;
                        w_state_d[k]     = (TurnaroundCycles == 0) ? StDrive : StTurn;
                    end
                end
                StDrive: begin
                    if (w_sel[k] && cfg_oe_ni_i) begin
                        w_tgt_drive_d[k] = 1'b0;
                        w_turn_cnt_d[k]  = TurnInit;
                        w_state_d[k]     = (TurnaroundCycles == 0) ? StInput : StTurn;
                    end
                end
                StTurn: begin
                    if (r_turn_cnt[k] == '0) begin
                        w_state_d[k] = r_tgt_drive[k] ? StDrive : StInput;
                    end else begin
                        w_turn_cnt_d[k] = r_turn_cnt[k] - TurnW'(1);
                    end
                end
                default: w_state_d[k] = StInput;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tgt_drive <= '0;
            r_pullup    <= '0;
            r_pulldown  <= '0;
            for (int unsigned k = 0; k < NumIo; k++) begin
                r_state[k]    <= StInput;
                r_turn_cnt[k] <= '0;
                r_strength[k] <= '0;
                r_thresh[k]   <= '0;
            end
        end else begin
            r_tgt_drive <= w_tgt_drive_d;
            for (int unsigned k = 0; k < NumIo; k++) begin
                r_state[k]    <= w_state_d[k];
                r_turn_cnt[k] <= w_turn_cnt_d[k];
                if (w_sel[k]) begin
                    r_strength[k] <= cfg_strength_i;
                    r_thresh[k]   <= cfg_debounce_i;
                    r_pullup[k]   <= cfg_pullup_i;
                    r_pulldown[k] <= cfg_pulldown_i;
                end
            end
        end
    end

    // Counter saturates rather than wrapping when the threshold drops below it mid-count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= '0;
            for (int unsigned k = 0; k < NumIo; k++) begin
                r_sync[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NumIo; k++) begin
                r_sync[k][0] <= io[k];
                for (int unsigned s = 1; s < SyncStages; s++) begin
                    r_sync[k][s] <= r_sync[k][s-1];
                end
                if (r_sync[k][SyncStages-1] == r_data[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == r_thresh[k]) begin
                    r_data[k] <= r_sync[k][SyncStages-1];
                    r_cnt[k]  <= '0;
                end else if (r_cnt[k] != '1) begin
                    r_cnt[k] <= r_cnt[k] + DebounceW'(1);
                end
            end
        end
    end

    assign data_o = r_data;

    for (genvar k = 0; k < NumIo; k++) begin : g_pad
        assign oe_no[k]              = (r_state[k] != StDrive);
        assign busy_o[k]             = (r_state[k] == StTurn);
        assign strength_o[4*k +: 4]  = r_strength[k];
        assign io[k]                 = oe_no[k] ? 1'bz : data_i[k];
    end

`ifdef TC_IO_BANK_PULL_EN
    for (genvar k = 0; k < NumIo; k++) begin : g_pull
        assign (weak1, highz0) io[k] = r_pullup[k];
        assign (highz1, weak0) io[k] = !r_pulldown[k];
    end
`else
    logic w_unused_pulls;
    assign w_unused_pulls = ^{r_pullup, r_pulldown};
`endif

endmodule
